fft_8point_stream_ctrl: RTL and testbench

//  Streaming sequencer for the 8-point FFT core. Collects a serial stream of

---
 rtl/fft_8point_stream_ctrl.sv | 168 ++++++++++++++++
 tb/tb_fft_8point_stream_ctrl.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_8point_stream_ctrl.sv
// ---------------------------------------------------------------------------
// fft_8point_stream_ctrl
//
// Streaming sequencer for an 8-point FFT core.
//   Input side : collects a serial stream of signed samples into 8-sample
//                frames and hands each complete frame to the core over a
//                valid/ready port.
//   Output side: captures each 8-bin result from the core and replays it
//                bin by bin on a serial valid/ready port.
//   Results pass through bit-exact. Samples are not extended.
//
// Parameters
//   SAMPLE_W  sample width, equal to the core input width
//   RESULT_W  per-component result width, equal to the core output width
//
// Ports
//   clk, reset_n             clock (rising edge), asynchronous active-low reset
//   s_valid/s_ready/s_data   serial sample input, frame order x0..x7
//   fft_s_valid/fft_s_ready  frame handshake to the core
//   fft_x                    frame to the core, xk at [k*SAMPLE_W +: SAMPLE_W]
//   fft_m_valid/fft_m_ready  result handshake from the core
//   fft_X                    result, bin k real at [2k*W +: W], imag at [(2k+1)*W +: W]
//   m_valid/m_ready          serial bin output handshake
//   m_real/m_imag/m_bin      current bin value and index
//   m_last                   high with bin 7
//   inflight                 frames issued to the core but not yet captured
//   busy                     partial frame, frame waiting to issue, frames in
//                            the core, or result buffer occupied
//   flush                    (only when FFT_STREAM_FLUSH_EN is defined)
//                            synchronous discard of a partial input frame
//
// Optional feature macro: FFT_STREAM_FLUSH_EN
// ---------------------------------------------------------------------------
module fft_8point_stream_ctrl #(
    parameter int SAMPLE_W = 8,
    parameter int RESULT_W = 32
) (
    input  logic                           clk,
    input  logic                           reset_n,
`ifdef FFT_STREAM_FLUSH_EN
    input  logic                           flush,
`endif
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic signed [SAMPLE_W-1:0]     s_data,
    output logic                           fft_s_valid,
    input  logic                           fft_s_ready,
    output logic        [8*SAMPLE_W-1:0]   fft_x,
    input  logic                           fft_m_valid,
    output logic                           fft_m_ready,
    input  logic        [16*RESULT_W-1:0]  fft_X,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic signed [RESULT_W-1:0]     m_real,
    output logic signed [RESULT_W-1:0]     m_imag,
    output logic        [2:0]              m_bin,
    output logic                           m_last,
    output logic        [1:0]              inflight,
    output logic                           busy
);

    typedef enum logic { COLLECT = 1'b0, ISSUE = 1'b1 } in_state_t;
    typedef enum logic { EMPTY   = 1'b0, FULL  = 1'b1 } out_state_t;

    in_state_t                    in_state;
    out_state_t                   out_state;
    logic                         live;
    logic        [2:0]            wr_cnt;
    logic        [2:0]            rd_cnt;
    logic signed [SAMPLE_W-1:0]   sbuf [8];
    logic signed [RESULT_W-1:0]   obuf [16];

    logic s_hs, fs_hs, fm_hs, m_hs, flush_c;

`ifdef FFT_STREAM_FLUSH_EN
    assign flush_c = flush;
`else
    assign flush_c = 1'b0;
`endif

    // live gates the ready outputs so every output reads 0 while reset is
    // held; readiness appears on the first clock after release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) live <= 1'b0;
        else          live <= 1'b1;
    end

    assign s_ready     = live & (in_state == COLLECT);
    assign fft_s_valid = (in_state == ISSUE);
    assign m_valid     = (out_state == FULL);
    assign m_last      = m_valid & (rd_cnt == 3'd7);
    assign m_bin       = rd_cnt;
    // Accepting a new result while the last bin leaves keeps FULL without
    // a bubble between frames.
    assign fft_m_ready = live & ((out_state == EMPTY) | (m_ready & m_last));

    assign s_hs  = s_valid & s_ready;
    assign fs_hs = fft_s_valid & fft_s_ready;
    assign fm_hs = fft_m_valid & fft_m_ready;
    assign m_hs  = m_valid & m_ready;

    // Input FSM: sample collection and frame issue
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_state <= COLLECT;
            wr_cnt   <= 3'd0;
            for (int i = 0; i < 8; i++) sbuf[i] <= '0;
        end else if (in_state == COLLECT) begin
            // A flush wins over a sample arriving in the same cycle.
            if (flush_c) begin
                wr_cnt <= 3'd0;
            end else if (s_hs) begin
                sbuf[wr_cnt] <= s_data;
                wr_cnt       <= wr_cnt + 3'd1;  // wraps to 0 after slot 7
                if (wr_cnt == 3'd7) in_state <= ISSUE;
            end
        end else begin
            if (fft_s_ready) in_state <= COLLECT;
        end
    end

    // The frame is presented straight from the registered buffer, so it is
    // stable for the whole ISSUE wait.
    always_comb begin
        fft_x = '0;
        for (int k = 0; k < 8; k++) fft_x[k*SAMPLE_W +: SAMPLE_W] = sbuf[k];
    end

    // Output FSM: result capture and bin replay
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_state <= EMPTY;
            rd_cnt    <= 3'd0;
            for (int i = 0; i < 16; i++) obuf[i] <= '0;
        end else if (fm_hs) begin
            out_state <= FULL;
            rd_cnt    <= 3'd0;
            for (int i = 0; i < 16; i++) obuf[i] <= fft_X[i*RESULT_W +: RESULT_W];
        end else if (m_hs) begin
            rd_cnt <= rd_cnt + 3'd1;
            if (rd_cnt == 3'd7) out_state <= EMPTY;
        end
    end

    assign m_real = obuf[{rd_cnt, 1'b0}];
    assign m_imag = obuf[{rd_cnt, 1'b1}];

    // Frames inside the core
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight <= 2'd0;
        end else begin
            case ({fs_hs, fm_hs})
                2'b10:   inflight <= inflight + 2'd1;
                2'b01:   inflight <= inflight - 2'd1;
                default: inflight <= inflight;
            endcase
        end
    end

    // The core must stall its input before a fourth frame is in flight.
    inflight_bound: assert property (@(posedge clk) disable iff (!reset_n)
        !(fs_hs && !fm_hs && inflight == 2'd3));

    assign busy = (wr_cnt != 3'd0) | (in_state == ISSUE) |
                  (inflight != 2'd0) | (out_state == FULL);

endmodule

// File: tb/tb_fft_8point_stream_ctrl.sv
module tb_fft_8point_stream_ctrl;

    localparam int SW = 8;
    localparam int RW = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    initial forever #5 clk = ~clk;

    logic                  s_valid = 1'b0;
    logic                  s_ready;
    logic signed [SW-1:0]  s_data = '0;
    logic                  fft_s_valid;
    logic                  fft_s_ready;
    logic [8*SW-1:0]       fft_x;
    logic                  fft_m_valid;
    logic                  fft_m_ready;
    logic [16*RW-1:0]      fft_X;
    logic                  m_valid;
    logic                  m_ready;
    logic [RW-1:0]         m_real;
    logic [RW-1:0]         m_imag;
    logic [2:0]            m_bin;
    logic                  m_last;
    logic [1:0]            inflight;
    logic                  busy;
`ifdef FFT_STREAM_FLUSH_EN
    logic                  flush = 1'b0;
`endif

    logic m_ready_set = 1'b1;
    logic m_toggle    = 1'b0;
    logic tog_phase   = 1'b0;
    assign m_ready = m_toggle ? tog_phase : m_ready_set;

    fft_8point_stream_ctrl #(.SAMPLE_W(SW), .RESULT_W(RW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
`ifdef FFT_STREAM_FLUSH_EN
        .flush      (flush),
`endif
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .fft_s_valid(fft_s_valid),
        .fft_s_ready(fft_s_ready),
        .fft_x      (fft_x),
        .fft_m_valid(fft_m_valid),
        .fft_m_ready(fft_m_ready),
        .fft_X      (fft_X),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_real     (m_real),
        .m_imag     (m_imag),
        .m_bin      (m_bin),
        .m_last     (m_last),
        .inflight   (inflight),
        .busy       (busy)
    );

    // ---------------- core model: 3-deep pipe honouring ready -------------
    logic [8*SW-1:0]  core_q[$];
    int               core_ts[$];
    int               cyc;
    logic             core_s_ready;
    logic             core_m_valid;
    logic [16*RW-1:0] core_X;
    logic             core_hold = 1'b0;

    assign fft_s_ready = core_s_ready & ~core_hold;
    assign fft_m_valid = core_m_valid;
    assign fft_X       = core_X;

    function automatic logic [16*RW-1:0] mk_X(input logic [8*SW-1:0] x);
        logic [16*RW-1:0] r;
        logic signed [SW-1:0] xs;
        logic signed [RW-1:0] re;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            xs = x[k*SW +: SW];
            re = {{(RW-SW){xs[SW-1]}}, xs};
            r[2*k*RW +: RW]     = re;
            r[(2*k+1)*RW +: RW] = -re;
        end
        return r;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_q.delete();
            core_ts.delete();
            cyc          <= 0;
            core_s_ready <= 1'b0;
            core_m_valid <= 1'b0;
            core_X       <= '0;
        end else begin
            if (core_m_valid && fft_m_ready) begin
                void'(core_q.pop_front());
                void'(core_ts.pop_front());
            end
            if (fft_s_valid && fft_s_ready) begin
                core_q.push_back(fft_x);
                core_ts.push_back(cyc);
            end
            cyc          <= cyc + 1;
            core_s_ready <= (core_q.size() < 3);
            if (core_q.size() > 0) begin
                core_m_valid <= (cyc - core_ts[0] >= 2);
                core_X       <= mk_X(core_q[0]);
            end else begin
                core_m_valid <= 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (m_toggle) tog_phase = ~tog_phase;
    end

    // ---------------- scoreboard ------------------------------------------
    typedef struct packed {
        logic [RW-1:0] re;
        logic [RW-1:0] im;
        logic [2:0]    bin;
        logic          last;
    } bin_t;

    bin_t                 exp_q[$];
    logic signed [SW-1:0] frame_acc[$];

    int checks = 0, fails = 0;
    int mchecks = 0, mfails = 0;
    int issue_cnt = 0, nobubble_cnt = 0;

    // Output monitor: scoreboard pops, hold-while-stalled, no-bubble.
    initial begin
        bin_t cur, prev_out, e;
        logic prev_stall, expect_full;
        prev_stall = 1'b0;
        expect_full = 1'b0;
        prev_out = '0;
        forever begin
            @(negedge clk);
            #2;
            cur = '{re: m_real, im: m_imag, bin: m_bin, last: m_last};
            if (!reset_n) begin
                prev_stall  = 1'b0;
                expect_full = 1'b0;
            end else begin
                if (expect_full) begin
                    mchecks++;
                    if (!(m_valid === 1'b1 && m_bin === 3'd0)) begin
                        mfails++;
                        $display("FAIL no_bubble: m_valid=%0b m_bin=%0d, required 1/0", m_valid, m_bin);
                    end else nobubble_cnt++;
                end
                if (prev_stall) begin
                    mchecks++;
                    if (m_valid !== 1'b1 || cur !== prev_out) begin
                        mfails++;
                        $display("FAIL hold_stall: got v=%0b %h, required v=1 %h", m_valid, cur, prev_out);
                    end
                end
                if (fft_s_valid && fft_s_ready) issue_cnt++;
                expect_full = m_valid && m_ready && m_last && fft_m_valid;
                prev_stall  = m_valid && !m_ready;
                prev_out    = cur;
                if (m_valid && m_ready) begin
                    mchecks++;
                    if (exp_q.size() == 0) begin
                        mfails++;
                        $display("FAIL unexpected_bin: got %h, required none", cur);
                    end else begin
                        e = exp_q.pop_front();
                        if (cur !== e) begin
                            mfails++;
                            $display("FAIL bin_data: got re=%0d im=%0d bin=%0d last=%0b, required re=%0d im=%0d bin=%0d last=%0b",
                                     $signed(cur.re), $signed(cur.im), cur.bin, cur.last,
                                     $signed(e.re), $signed(e.im), e.bin, e.last);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ------------------------------------
    function automatic logic [8*SW-1:0] pack_seq(input int base);
        logic [8*SW-1:0] r;
        for (int k = 0; k < 8; k++) r[k*SW +: SW] = SW'(base + k);
        return r;
    endfunction

    task automatic send_sample(input logic signed [SW-1:0] v);
        int n;
        logic signed [RW-1:0] re;
        s_valid = 1'b1;
        s_data  = v;
        n = 0;
        while (s_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (s_ready !== 1'b1) begin
            fails++;
            $display("FAIL sample_accept: s_ready=%0b after %0d cycles, required 1", s_ready, n);
        end else begin
            frame_acc.push_back(v);
            if (frame_acc.size() == 8) begin
                for (int k = 0; k < 8; k++) begin
                    re = {{(RW-SW){frame_acc[k][SW-1]}}, frame_acc[k]};
                    exp_q.push_back('{re: re, im: -re, bin: 3'(k), last: (k == 7)});
                end
                frame_acc.delete();
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic send_frame(input int base);
        for (int k = 0; k < 8; k++) send_sample(SW'(base + k));
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
    endtask

    // ---------------- tests -----------------------------------------------
    task automatic test_reset;
        #1;
        checks++;
        if ({s_ready, fft_s_valid, fft_m_ready, m_valid, m_last, busy, inflight, m_bin} !== '0 ||
            m_real !== '0 || m_imag !== '0 || fft_x !== '0) begin
            fails++;
            $display("FAIL reset_outputs: s_rdy=%0b fsv=%0b fmr=%0b mv=%0b busy=%0b infl=%0d x=%h, required all 0",
                     s_ready, fft_s_valid, fft_m_ready, m_valid, busy, inflight, fft_x);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({s_ready, fft_m_ready, fft_s_valid, m_valid, busy} !== 5'b11000) begin
            fails++;
            $display("FAIL after_reset: s_rdy=%0b fmr=%0b fsv=%0b mv=%0b busy=%0b, required 1 1 0 0 0",
                     s_ready, fft_m_ready, fft_s_valid, m_valid, busy);
        end
    endtask

    task automatic test_single_frame;
        int ic0;
        ic0 = issue_cnt;
        m_ready_set = 1'b1;
        send_frame(1);
        checks++;
        if (fft_s_valid !== 1'b1 || fft_x !== pack_seq(1)) begin
            fails++;
            $display("FAIL issue_frame: fsv=%0b x=%h, required 1 %h", fft_s_valid, fft_x, pack_seq(1));
        end
        checks++;
        if (s_ready !== 1'b0) begin
            fails++;
            $display("FAIL s_ready_issue: got %0b, required 0", s_ready);
        end
        wait_drain(200);
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL single_drain: %0d bins left, required 0", exp_q.size());
        end
        checks++;
        if (issue_cnt - ic0 != 1) begin
            fails++;
            $display("FAIL issue_count: got %0d, required 1", issue_cnt - ic0);
        end
        checks++;
        if ({inflight, busy, m_valid} !== 4'b0000) begin
            fails++;
            $display("FAIL idle: infl=%0d busy=%0b mv=%0b, required 0 0 0", inflight, busy, m_valid);
        end
    endtask

    task automatic test_issue_stall;
        core_hold = 1'b1;
        send_frame(10);
        s_valid = 1'b1;
        s_data  = SW'(20);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({fft_s_valid, s_ready} !== 2'b10 || fft_x !== pack_seq(10)) begin
                fails++;
                $display("FAIL issue_stall c%0d: fsv=%0b s_rdy=%0b x=%h, required 1 0 %h",
                         c, fft_s_valid, s_ready, fft_x, pack_seq(10));
            end
            @(negedge clk);
        end
        core_hold = 1'b0;
        send_frame(20);
        wait_drain(300);
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL stall_drain: %0d bins left, required 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure;
        int bases[5];
        bases = '{1, -60, 100, -128, 120};
        m_ready_set = 1'b0;
        for (int f = 0; f < 5; f++) send_frame(bases[f]);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({s_ready, fft_s_valid, m_valid, busy} !== 4'b0111 || inflight !== 2'd3) begin
                fails++;
                $display("FAIL backpressure c%0d: s_rdy=%0b fsv=%0b mv=%0b busy=%0b infl=%0d, required 0 1 1 1 3",
                         c, s_ready, fft_s_valid, m_valid, busy, inflight);
            end
            @(negedge clk);
        end
        m_ready_set = 1'b1;
        wait_drain(800);
        checks++;
        if (exp_q.size() != 0 || inflight !== 2'd0) begin
            fails++;
            $display("FAIL backpressure_drain: %0d bins left infl=%0d, required 0 0", exp_q.size(), inflight);
        end
    endtask

    task automatic test_toggle;
        int nb0;
        nb0 = nobubble_cnt;
        m_toggle = 1'b1;
        send_frame(30);
        send_frame(38);
        send_frame(46);
        wait_drain(1000);
        m_toggle = 1'b0;
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL toggle_drain: %0d bins left, required 0", exp_q.size());
        end
        checks++;
        if (nobubble_cnt == nb0) begin
            fails++;
            $display("FAIL back_to_back: no-bubble transitions seen %0d, required >0", nobubble_cnt - nb0);
        end
    endtask

    task automatic test_reset_mid;
        m_ready_set = 1'b0;
        send_frame(60);
        send_frame(70);
        for (int k = 0; k < 5; k++) send_sample(SW'(80 + k));
        checks++;
        if ({inflight, busy, m_valid} !== 4'b0111) begin
            fails++;
            $display("FAIL pre_reset: infl=%0d busy=%0b mv=%0b, required 1 1 1", inflight, busy, m_valid);
        end
        reset_n = 1'b0;
        exp_q.delete();
        frame_acc.delete();
        #1;
        checks++;
        if ({s_ready, fft_s_valid, fft_m_ready, m_valid, m_last, busy, inflight, m_bin} !== '0 ||
            m_real !== '0 || m_imag !== '0 || fft_x !== '0) begin
            fails++;
            $display("FAIL mid_reset_outputs: s_rdy=%0b fsv=%0b fmr=%0b mv=%0b busy=%0b infl=%0d re=%0d x=%h, required all 0",
                     s_ready, fft_s_valid, fft_m_ready, m_valid, busy, inflight, m_real, fft_x);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        m_ready_set = 1'b1;
        @(negedge clk);
        send_frame(-5);
        checks++;
        if (fft_s_valid !== 1'b1 || fft_x !== pack_seq(-5)) begin
            fails++;
            $display("FAIL fresh_frame: fsv=%0b x=%h, required 1 %h", fft_s_valid, fft_x, pack_seq(-5));
        end
        wait_drain(200);
        repeat (30) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_drain: %0d bins left busy=%0b, required 0 0", exp_q.size(), busy);
        end
    endtask

`ifdef FFT_STREAM_FLUSH_EN
    task automatic test_flush;
        for (int k = 1; k <= 3; k++) send_sample(SW'(k));
        flush   = 1'b1;
        s_valid = 1'b1;
        s_data  = SW'(99);
        @(negedge clk);
        flush   = 1'b0;
        s_valid = 1'b0;
        frame_acc.delete();
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL flush_busy: got %0b, required 0", busy);
        end
        send_frame(9);
        checks++;
        if (fft_s_valid !== 1'b1 || fft_x !== pack_seq(9)) begin
            fails++;
            $display("FAIL flush_frame: fsv=%0b x=%h, required 1 %h", fft_s_valid, fft_x, pack_seq(9));
        end
        wait_drain(200);
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL flush_drain: %0d bins left, required 0", exp_q.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_issue_stall();
        test_backpressure();
        test_toggle();
        test_reset_mid();
`ifdef FFT_STREAM_FLUSH_EN
        test_flush();
`endif
        repeat (5) @(negedge clk);
        checks += mchecks;
        fails  += mfails;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
